// File: rtl/gmii_rx_deframer_pkg.sv
// gmii_rx_deframer_pkg
//   Shared constants and types for the GMII receive deframer and the
//   byte-wide CRC-32 helper. The TX framer also uses these.
//   Contents: preamble/SFD byte values, reflected CRC-32 constants,
//   preamble counter saturation value, receive FSM state encoding.
`timescale 1ns/1ps
package gmii_rx_deframer_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    // Reflected CRC-32 (IEEE 802.3), processed LSB-first.
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Register value after running a good frame, FCS included, with no final XOR.
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam logic [2:0]  PRE_CNT_SAT   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } rx_state_t;

endpackage

// File: rtl/gmii_rx_deframer_crc32_byte.sv
// crc32_byte
//   Combinational next-state of the reflected Ethernet CRC-32 for one byte.
//   Ports:
//     crc_in  [31:0]  current CRC register
//     data    [7:0]   byte, consumed LSB-first
//     crc_out [31:0]  CRC register after the byte
`timescale 1ns/1ps
module crc32_byte
    import gmii_rx_deframer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer
//   GMII receive front end: strips preamble/SFD, checks the Ethernet FCS,
//   withholds the 4 FCS bytes and forwards the frame body as a contiguous
//   rx_en_w/rxdata_w byte stream, with a one-cycle end-of-frame status.
//   Ports:
//     clk, rst                     byte clock, async active-high reset
//     gmii_rx_dv/er, gmii_rxd[7:0] GMII receive pins (already in clk domain)
//     rx_en_w, rxdata_w[7:0]       forwarded body bytes
//     frame_done                   one-cycle pulse at end of a frame that reached DATA
//     crc_ok                       FCS good, no rx_er, >=5 bytes; valid with frame_done
//     rx_len[CNT_W-1:0]            forwarded body byte count; valid with frame_done
`timescale 1ns/1ps
module gmii_rx_deframer
    import gmii_rx_deframer_pkg::*;
#(
    parameter int MIN_PRE = 2,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    input  logic [7:0]       gmii_rxd,
    output logic             rx_en_w,
    output logic [7:0]       rxdata_w,
    output logic             frame_done,
    output logic             crc_ok,
    output logic [CNT_W-1:0] rx_len
);

    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] FCS_CNT    = CNT_W'(4);
    localparam logic [CNT_W-1:0] MIN_OK_CNT = CNT_W'(5);
    localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);
    localparam logic [2:0]       PRE_MIN    = 3'(MIN_PRE);

    rx_state_t        state;
    logic [2:0]       pre_cnt;
    logic [31:0]      crc;
    logic [31:0]      crc_next;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             armed;
    logic [7:0]       dly [0:3];

    crc32_byte u_crc (
        .crc_in  (crc),
        .data    (gmii_rxd),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pre_cnt    <= '0;
            crc        <= CRC32_INIT;
            cnt        <= '0;
            err        <= 1'b0;
            armed      <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                dly[i] <= '0;
            end
            rx_en_w    <= 1'b0;
            rxdata_w   <= '0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
            rx_len     <= '0;
        end else begin
            rx_en_w    <= 1'b0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
            rx_len     <= '0;

            // A reset that lands mid-frame must not let the frame tail be
            // mistaken for a new preamble: stay deaf until dv has been low.
            if (!gmii_rx_dv) begin
                armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (gmii_rx_dv && armed) begin
                        if (gmii_rxd == PREAMBLE_BYTE) begin
                            state   <= ST_PRE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end

                ST_PRE: begin
                    if (!gmii_rx_dv) begin
                        state <= ST_IDLE;
                    end else if (gmii_rxd == PREAMBLE_BYTE) begin
                        if (pre_cnt != PRE_CNT_SAT) begin
                            pre_cnt <= pre_cnt + 3'd1;
                        end
                    end else if (gmii_rxd == SFD_BYTE && pre_cnt >= PRE_MIN) begin
                        state <= ST_DATA;
                        crc   <= CRC32_INIT;
                        cnt   <= '0;
                        err   <= 1'b0;
                        for (int unsigned i = 0; i < 4; i++) begin
                            dly[i] <= '0;
                        end
                    end else begin
                        state <= ST_DROP;
                    end
                end

                ST_DATA: begin
                    if (!gmii_rx_dv) begin
                        // End of frame: whatever is left in the delay line is the FCS.
                        frame_done <= 1'b1;
                        rx_len     <= (cnt >= FCS_CNT) ? cnt - FCS_CNT : '0;
                        crc_ok     <= (crc == CRC32_RESIDUE) && (cnt >= MIN_OK_CNT) && !err;
                        state      <= ST_IDLE;
                        for (int unsigned i = 0; i < 4; i++) begin
                            dly[i] <= '0;
                        end
                    end else if (cnt == MAX_CNT) begin
                        // Oversize: close the frame as bad and discard the rest.
                        frame_done <= 1'b1;
                        rx_len     <= MAX_CNT - FCS_CNT;
                        state      <= ST_DROP;
                    end else begin
                        crc <= crc_next;
                        cnt <= cnt + ONE_CNT;
                        if (gmii_rx_er) begin
                            err <= 1'b1;
                        end
                        dly[0] <= gmii_rxd;
                        dly[1] <= dly[0];
                        dly[2] <= dly[1];
                        dly[3] <= dly[2];
                        // Line full: the oldest byte can no longer be part of the FCS.
                        if (cnt >= FCS_CNT) begin
                            rx_en_w  <= 1'b1;
                            rxdata_w <= dly[3];
                        end
                    end
                end

                ST_DROP: begin
                    if (!gmii_rx_dv) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// tb_gmii_rx_deframer
//   Self-checking bench for gmii_rx_deframer: a table of directed frames with
//   constant expectations, hand-written latency/oversize/reset sequences, and
//   randomized frames scored against a frame-level reference model.
`timescale 1ns/1ps
module tb_gmii_rx_deframer;

    localparam int MIN_PRE = 2;
    localparam int MAX_LEN = 1518;
    localparam int CNT_W   = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             gmii_rx_dv;
    logic             gmii_rx_er;
    logic [7:0]       gmii_rxd;
    logic             rx_en_w;
    logic [7:0]       rxdata_w;
    logic             frame_done;
    logic             crc_ok;
    logic [CNT_W-1:0] rx_len;

    gmii_rx_deframer #(
        .MIN_PRE (MIN_PRE),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .gmii_rxd   (gmii_rxd),
        .rx_en_w    (rx_en_w),
        .rxdata_w   (rxdata_w),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .rx_len     (rx_len)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit ok;
        int len;
        int nbytes;
    } rec_t;

    typedef struct {
        int         npre;
        logic [7:0] sfd;
        int         nbody;
        bit         bad_fcs;
        int         er_body;
        bit         exp_done;
        bit         exp_ok;
        int         exp_len;
    } vec_t;

    rec_t       got_q[$];
    rec_t       exp_q[$];
    logic [7:0] got_bytes[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] post[$];
    logic [7:0] wq[$];
    vec_t       tbl[$];
    int         fcount   = 0;
    int         overlap  = 0;
    int         first_out = -1;
    int         last_out  = -1;
    int         mark_idx  = -1;
    int         mark_cyc  = -1;

    // Output monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_en_w) begin
                got_bytes.push_back(rxdata_w);
                fcount++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (frame_done) begin
                rec_t r;
                r.ok     = crc_ok;
                r.len    = int'(rx_len);
                r.nbytes = fcount;
                got_q.push_back(r);
                fcount = 0;
                if (rx_en_w) overlap++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference CRC: standard reflected CRC-32 with final inversion (the FCS value).
    function automatic logic [31:0] fcs_of(input logic [7:0] q[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic append_fcs();
        logic [31:0] f;
        f = fcs_of(post, post.size());
        post.push_back(f[7:0]);
        post.push_back(f[15:8]);
        post.push_back(f[23:16]);
        post.push_back(f[31:24]);
    endtask

    // Frame-level model: what the receiver should report for one frame.
    task automatic model_frame(input int npre, input logic [7:0] sfd, input bit er_hit);
        int   n;
        int   nf;
        rec_t r;
        logic [31:0] fcs_rx;
        n = post.size();
        if (npre < MIN_PRE || sfd != 8'hD5) return;
        if (n > MAX_LEN) begin
            nf   = MAX_LEN - 4;
            r.ok = 1'b0;
        end else begin
            nf   = (n >= 4) ? n - 4 : 0;
            r.ok = 1'b0;
            if (n >= 5 && !er_hit) begin
                fcs_rx = {post[n-1], post[n-2], post[n-3], post[n-4]};
                r.ok   = (fcs_of(post, nf) == fcs_rx);
            end
        end
        r.len    = nf;
        r.nbytes = nf;
        exp_q.push_back(r);
        for (int i = 0; i < nf; i++) exp_bytes.push_back(post[i]);
    endtask

    task automatic build_wire(input int npre, input logic [7:0] sfd);
        wq.delete();
        for (int i = 0; i < npre; i++) wq.push_back(8'h55);
        wq.push_back(sfd);
        foreach (post[i]) wq.push_back(post[i]);
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic e);
        @(posedge clk); #1;
        gmii_rx_dv = 1'b1;
        gmii_rxd   = b;
        gmii_rx_er = e;
    endtask

    task automatic send(input int er_at, input int gap);
        for (int i = 0; i < wq.size(); i++) begin
            drive_byte(wq[i], i == er_at);
            if (i == mark_idx) mark_cyc = cyc;
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            gmii_rx_dv = 1'b0;
            gmii_rx_er = 1'b0;
            gmii_rxd   = 8'($urandom);
        end
    endtask

    task automatic end_phase(input string name);
        int nmin;
        int nmis;
        int first_bad;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk({name, ".frames"}, got_q.size(), exp_q.size());
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            chk($sformatf("%s.f%0d.crc_ok", name, i), got_q[i].ok, exp_q[i].ok);
            chk($sformatf("%s.f%0d.rx_len", name, i), got_q[i].len, exp_q[i].len);
            chk($sformatf("%s.f%0d.nbytes", name, i), got_q[i].nbytes, exp_q[i].nbytes);
        end
        chk({name, ".total_bytes"}, got_bytes.size(), exp_bytes.size());
        nmin = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
        nmis = 0;
        first_bad = -1;
        for (int i = 0; i < nmin; i++) begin
            if (got_bytes[i] !== exp_bytes[i]) begin
                nmis++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (first_bad >= 0)
            chk($sformatf("%s.byte_mismatches(first @%0d got %02h want %02h)", name, first_bad,
                          got_bytes[first_bad], exp_bytes[first_bad]), nmis, 0);
        else
            chk({name, ".byte_mismatches"}, nmis, 0);
        chk({name, ".en_with_done"}, overlap, 0);
        got_q.delete();
        exp_q.delete();
        got_bytes.delete();
        exp_bytes.delete();
        fcount    = 0;
        overlap   = 0;
        first_out = -1;
        last_out  = -1;
    endtask

    function automatic vec_t mk(input int npre, input logic [7:0] sfd, input int nbody,
                                input bit bad, input int er_body, input bit d, input bit ok,
                                input int len);
        vec_t v;
        v.npre = npre; v.sfd = sfd; v.nbody = nbody; v.bad_fcs = bad; v.er_body = er_body;
        v.exp_done = d; v.exp_ok = ok; v.exp_len = len;
        return v;
    endfunction

    // Table frame: body 0x31,0x32,... then FCS, expectations from the record.
    task automatic run_vec(input vec_t v, input int gap);
        rec_t r;
        post.delete();
        for (int i = 0; i < v.nbody; i++) post.push_back(8'(8'h31 + i));
        append_fcs();
        if (v.bad_fcs) post[post.size()-1] = post[post.size()-1] ^ 8'h01;
        build_wire(v.npre, v.sfd);
        if (v.exp_done) begin
            r.ok = v.exp_ok; r.len = v.exp_len; r.nbytes = v.exp_len;
            exp_q.push_back(r);
            for (int i = 0; i < v.exp_len; i++) exp_bytes.push_back(post[i]);
        end
        send((v.er_body >= 0) ? v.npre + 1 + v.er_body : -1, gap);
    endtask

    initial begin
        rec_t r;
        int   npre;
        int   gap;
        int   er_at;
        int   k;
        logic [7:0] sfd;
        logic [7:0] bad_sfds [3];
        bad_sfds[0] = 8'hD4; bad_sfds[1] = 8'h5D; bad_sfds[2] = 8'h00;

        //         npre sfd    nbody bad  er  done ok len
        tbl.push_back(mk(7, 8'hD5,  9, 0, -1, 1, 1,  9)); // reference good frame
        tbl.push_back(mk(7, 8'hD5,  9, 1, -1, 1, 0,  9)); // last FCS byte CB -> CA
        tbl.push_back(mk(7, 8'hD5,  9, 0,  4, 1, 0,  9)); // rx_er on body byte 0x35
        tbl.push_back(mk(1, 8'hD5,  9, 0, -1, 0, 0,  0)); // SFD after a single 0x55
        tbl.push_back(mk(2, 8'hD5,  9, 0, -1, 1, 1,  9)); // minimum preamble, one idle after drop
        tbl.push_back(mk(2, 8'hD5,  1, 0, -1, 1, 1,  1)); // 5 bytes after SFD: smallest good
        tbl.push_back(mk(3, 8'hD4,  9, 0, -1, 0, 0,  0)); // wrong SFD byte
        tbl.push_back(mk(7, 8'hD5,  0, 0, -1, 1, 0,  0)); // FCS only: too short to be good
        tbl.push_back(mk(8, 8'hD5, 46, 0, -1, 1, 1, 46)); // saturating preamble count
        tbl.push_back(mk(2, 8'hD5,  2, 1, -1, 1, 0,  2));

        rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.rx_en_w",    rx_en_w,    0);
        chk("reset.rxdata_w",   rxdata_w,   0);
        chk("reset.frame_done", frame_done, 0);
        chk("reset.crc_ok",     crc_ok,     0);
        chk("reset.rx_len",     rx_len,     0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Reference frame alone, with latency and contiguity of the body burst.
        mark_idx = 8; // first body byte follows 7 preamble bytes and the SFD
        run_vec(tbl[0], 1);
        mark_idx = -1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk("t1.latency", first_out - mark_cyc, 5);
        chk("t1.burst_span", last_out - first_out + 1, 9);
        end_phase("t1");

        // Remaining table frames back-to-back with one idle cycle between.
        for (int i = 1; i < tbl.size(); i++) run_vec(tbl[i], 1);
        end_phase("table");

        // Oversize frame: body of MAX_LEN+10 bytes after the SFD.
        post.delete();
        for (int i = 0; i < MAX_LEN + 10; i++) post.push_back(8'($urandom));
        model_frame(7, 8'hD5, 1'b0);
        build_wire(7, 8'hD5);
        send(-1, 1);
        end_phase("oversize");

        // Reset while the body is being forwarded, then the frame tail and a
        // complete-looking frame arrive before dv ever drops.
        post.delete();
        for (int i = 0; i < 9; i++) post.push_back(8'(8'h31 + i));
        append_fcs();
        build_wire(7, 8'hD5);
        for (int i = 0; i <= 13; i++) drive_byte(wq[i], 1'b0); // up to 6th body byte
        #1;
        chk("rst.pre_rx_en_w",  rx_en_w,  1);
        chk("rst.pre_rxdata_w", rxdata_w, 8'h31);
        rst = 1'b1;
        #1;
        chk("rst.async_rx_en_w",    rx_en_w,    0);
        chk("rst.async_rxdata_w",   rxdata_w,   0);
        chk("rst.async_frame_done", frame_done, 0);
        drive_byte(wq[14], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 15; i < wq.size(); i++) drive_byte(wq[i], 1'b0);
        for (int i = 0; i < 4; i++) drive_byte(8'h55, 1'b0);
        drive_byte(8'hD5, 1'b0);
        foreach (post[i]) drive_byte(post[i], 1'b0);
        @(posedge clk); #1;
        gmii_rx_dv = 1'b0;
        end_phase("rst_abort");
        run_vec(tbl[0], 1);
        end_phase("rst_recover");

        // Randomized frames against the model.
        for (int f = 0; f < 40; f++) begin
            npre = $urandom_range(0, 8);
            sfd  = ($urandom_range(0, 5) == 0) ? bad_sfds[$urandom_range(0, 2)] : 8'hD5;
            post.delete();
            k = $urandom_range(0, 30);
            for (int i = 0; i < k; i++) post.push_back(8'($urandom));
            append_fcs();
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, post.size() - 1);
                post[k] = post[k] ^ (8'h01 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, post.size());
                while (post.size() > k) void'(post.pop_back());
            end
            er_at = -1;
            if (post.size() > 0 && $urandom_range(0, 5) == 0)
                er_at = $urandom_range(0, post.size() - 1);
            gap = $urandom_range(1, 3);
            model_frame(npre, sfd, er_at >= 0);
            build_wire(npre, sfd);
            send((er_at >= 0) ? npre + 1 + er_at : -1, gap);
        end
        end_phase("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gmii_rx_deframer.md
Name: gmii_rx_deframer

Overview:
- Receive-side front end between the GMII receive pins (already in the clk domain) and the triple-redundancy voter (three2one).
- Strips preamble and SFD, checks the Ethernet FCS (CRC-32), and removes the 4 FCS bytes from the forwarded stream.
- Emits the frame body as the rx_en_w/rxdata_w byte stream the voter consumes, plus a one-cycle end-of-frame status pulse.

Parameters:
MIN_PRE, 2, minimum count of 0x55 bytes required before 0xD5 for the SFD to be accepted
MAX_LEN, 1518, maximum bytes after SFD (body + FCS) before the frame is abandoned
CNT_W, 11, width of the post-SFD byte counter; must hold MAX_LEN

Ports:
clk  in  1  byte clock, 125 MHz
rst  in  1  asynchronous active-high reset
gmii_rx_dv  in  1  receive data valid
gmii_rx_er  in  1  receive error
gmii_rxd  in  8  receive byte
rx_en_w  out  1  forwarded body byte valid; stays high and contiguous for one frame
rxdata_w  out  8  forwarded body byte
frame_done  out  1  one-cycle pulse at end of every frame that reached DATA
crc_ok  out  1  frame status; valid only while frame_done=1
rx_len  out  CNT_W  forwarded body byte count; valid while frame_done=1

Behaviour:
- Reset is asynchronous, active-high, and places the block in IDLE.
  - All outputs reset to 0, the shift register is emptied, CRC reset to 0xFFFFFFFF.
  - Reset asserted mid-frame discards the frame with no frame_done. After release the block stays in IDLE until gmii_rx_dv is next 0.
- All outputs are registered.
- FSM states: IDLE, PRE, DATA, DROP.
  - IDLE: dv=1 and rxd=0x55 -> PRE with pre_cnt=1. dv=1 with any other byte -> DROP.
  - PRE: rxd=0x55 -> pre_cnt++ (saturates at 7). rxd=0xD5 with pre_cnt>=MIN_PRE -> DATA; CRC set to 0xFFFFFFFF, byte count 0, err flag cleared. Any other byte, or 0xD5 too early -> DROP. dv=0 -> IDLE, no frame_done.
  - DATA:
    - Every byte with dv=1 updates the CRC and the byte count, and is shifted into a 4-byte delay line.
    - Once the line holds 4 bytes, each new byte evicts the oldest onto rxdata_w with rx_en_w=1.
    - Latency: a body byte present on gmii_rxd in cycle k appears on rxdata_w in cycle k+5.
    - The final 4 bytes (the FCS) are never forwarded.
    - gmii_rx_er=1 while dv=1 sets the err flag; forwarding continues.
  - DATA, dv falls:
    - Next cycle: rx_en_w=0 and frame_done=1.
    - rx_len = byte count - 4, or 0 if the count is below 4.
    - crc_ok=1 only if CRC register = 0xDEBB20E3, count>=5, and err=0.
    - Then -> IDLE. The delay line is flushed and its contents are not forwarded.
  - DATA, byte count reaches MAX_LEN with dv still high:
    - rx_en_w drops next cycle.
    - frame_done pulses with crc_ok=0 and rx_len = MAX_LEN-4.
    - -> DROP.
  - DROP: ignore input until dv=0, then -> IDLE. No frame_done.
- CRC details: reflected CRC-32, polynomial 0xEDB88320, LSB-first per byte, init 0xFFFFFFFF, no final XOR while checking.
- dv=0 for a single cycle always ends the frame; back-to-back frames need no extra idle beyond that cycle.
- rx_en_w is never high during the same cycle as frame_done.

Decomposition:
- Shared package holds:
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5
  - CRC32_POLY=0xEDB88320, CRC32_INIT=0xFFFFFFFF, CRC32_RESIDUE=0xDEBB20E3
  - FSM state encoding
- One sub-module: crc32_byte, a combinational next-CRC from (crc_in[31:0], data[7:0]). It is reused later by the TX framer.

Test Plan:
1. 7×0x55, 0xD5, body 31 32 33 34 35 36 37 38 39, FCS 26 39 F4 CB, then dv=0 -> rx_en_w high for 9 cycles with bytes 31..39; first byte 5 cycles after 0x31 input; frame_done=1, crc_ok=1, rx_len=9.
2. Same frame with the last FCS byte changed to CA -> identical 9 forwarded bytes; frame_done=1, crc_ok=0, rx_len=9.
3. Same frame with gmii_rx_er=1 on the body byte 0x35 -> bytes still forwarded; crc_ok=0.
4. 0x55, 0xD5 with MIN_PRE=2, then any bytes -> DROP: no rx_en_w, no frame_done. A valid frame right after one dv=0 cycle is received normally.
5. Preamble, SFD, then body of MAX_LEN+10 bytes -> exactly MAX_LEN-4 bytes forwarded; frame_done with crc_ok=0, rx_len=MAX_LEN-4; nothing more until dv=0.
6. rst pulsed at the 4th body byte of frame 1 -> outputs 0 immediately, no frame_done; the next valid frame passes with crc_ok=1.
